// File: rtl/osc_bank.sv
// Multi-channel phase-accumulator oscillator bank. Each sample tick sweeps every channel
// serially (one per clock) and emits a tagged (sample, channel, valid) stream.
module osc_bank #(
   parameter int NUM_CH  = 4,
   parameter int PHASE_W = 32,
   parameter int OUT_W   = 32,
   localparam int CH_W   = $clog2(NUM_CH)
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    step_in,
   input  logic                    cfg_we_in,
   input  logic [CH_W-1:0]         cfg_ch_in,
   input  logic [PHASE_W-1:0]      cfg_incr_in,
   input  logic [PHASE_W-1:0]      cfg_duty_in,
   input  logic [1:0]              cfg_mode_in,
   input  logic                    cfg_sync_in,
   output logic signed [OUT_W-1:0] amp_out,
   output logic [CH_W-1:0]         amp_ch_out,
   output logic                    amp_valid_out,
   output logic                    busy_out,
   output logic                    overrun_out
);

   typedef enum logic {S_IDLE, S_SWEEP} state_t;

   localparam logic [OUT_W-1:0]   MAX_AMP  = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0]   MIN_AMP  = {1'b1, {(OUT_W-1){1'b0}}};
   localparam logic [PHASE_W-1:0] HALF_PH  = {1'b1, {(PHASE_W-1){1'b0}}};
   localparam logic [CH_W:0]      NUM_CH_W = (CH_W+1)'(NUM_CH);

   state_t            r_state, w_nextState;
   logic [CH_W-1:0]   r_idx, w_nextIdx;
   logic              w_evalEn;
   logic [CH_W-1:0]   w_evalCh;

   logic [PHASE_W-1:0] r_phase [NUM_CH];
   logic [PHASE_W-1:0] r_incr  [NUM_CH];
   logic [PHASE_W-1:0] r_duty  [NUM_CH];
   logic [1:0]         r_mode  [NUM_CH];

   logic [OUT_W-1:0]   r_amp;
   logic [CH_W-1:0]    r_ampCh;
   logic               r_valid;
   logic               r_overrun;

   logic               w_cfgHit;
   logic [PHASE_W-1:0] w_p, w_duty, w_shift, w_tri;
   logic [1:0]         w_mode;
   logic [OUT_W-1:0]   w_top, w_triTop, w_wave;

   assign w_cfgHit = cfg_we_in && ({1'b0, cfg_ch_in} < NUM_CH_W);

   always_comb begin
      w_nextState = r_state;
      w_nextIdx   = r_idx;
      w_evalEn    = 1'b0;
      w_evalCh    = r_idx;
      case (r_state)
         S_IDLE: begin
            if (step_in) begin
               w_evalEn    = 1'b1;
               w_evalCh    = '0;
               w_nextState = S_SWEEP;
               w_nextIdx   = CH_W'(1);
            end
         end
         S_SWEEP: begin
            w_evalEn = 1'b1;
            if (r_idx == CH_W'(NUM_CH-1)) begin
               w_nextState = S_IDLE;
               w_nextIdx   = '0;
            end else begin
               w_nextIdx = r_idx + CH_W'(1);
            end
         end
         default: begin
            w_nextState = S_IDLE;
            w_nextIdx   = '0;
         end
      endcase
   end

   // Triangle folds the upper half of the phase back down before taking the top bits
   always_comb begin
      w_p      = r_phase[w_evalCh];
      w_duty   = r_duty[w_evalCh];
      w_mode   = r_mode[w_evalCh];
      w_top    = w_p[PHASE_W-1 -: OUT_W];
      w_shift  = w_p << 1;
      w_tri    = w_p[PHASE_W-1] ? ~w_shift : w_shift;
      w_triTop = w_tri[PHASE_W-1 -: OUT_W];
      w_wave   = '0;
      case (w_mode)
         2'd0:    w_wave = (w_p < w_duty) ? MAX_AMP : MIN_AMP;
         2'd1:    w_wave = {~w_top[OUT_W-1], w_top[OUT_W-2:0]};
         2'd2:    w_wave = {~w_triTop[OUT_W-1], w_triTop[OUT_W-2:0]};
         default: w_wave = '0;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_state   <= S_IDLE;
         r_idx     <= '0;
         r_amp     <= '0;
         r_ampCh   <= '0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_state   <= w_nextState;
         r_idx     <= w_nextIdx;
         r_valid   <= w_evalEn;
         r_overrun <= step_in && (r_state == S_SWEEP);
         if (w_evalEn) begin
            r_amp   <= w_wave;
            r_ampCh <= w_evalCh;
         end
      end
   end

   // A sync write wins over the accumulate when it targets the channel being evaluated
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int k = 0; k < NUM_CH; k++) begin
            r_phase[k] <= '0;
            r_incr[k]  <= '0;
            r_duty[k]  <= HALF_PH;
            r_mode[k]  <= 2'd0;
         end
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (w_cfgHit && (cfg_ch_in == CH_W'(k))) begin
               r_incr[k] <= cfg_incr_in;
               r_duty[k] <= cfg_duty_in;
               r_mode[k] <= cfg_mode_in;
            end
            if (w_cfgHit && (cfg_ch_in == CH_W'(k)) && cfg_sync_in) begin
               r_phase[k] <= '0;
            end else if (w_evalEn && (w_evalCh == CH_W'(k))) begin
               r_phase[k] <= r_phase[k] + r_incr[k];
            end
         end
      end
   end

   assign amp_out       = r_amp;
   assign amp_ch_out    = r_ampCh;
   assign amp_valid_out = r_valid;
   assign busy_out      = (r_state == S_SWEEP);
   assign overrun_out   = r_overrun;

endmodule
